// File: rtl/wb_trace_capture.sv
// Writeback trace recorder: captures register-file writes into a show-ahead FIFO
// until a programmable number of end-of-program rises, then drains and reports done.
module wb_trace_capture #(
  parameter int DEPTH     = 16,
  parameter int EOP_LIMIT = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 w_en,
  input  logic [2:0]                 aD_rf,
  input  logic [15:0]                wD_rf,
  input  logic                       eop,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [20:0]                rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [7:0]                 eop_cnt,
  output logic [15:0]                signature,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]  EOP_LAST = 8'(EOP_LIMIT - 1);

  typedef enum logic [1:0] {CAPTURE, DRAIN, FINISHED} state_t;

  state_t        state_reg, state_next;
  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_next;
  logic          eop_q;
  logic          full, pop, push, accept, eop_rise, eop_hit;

  assign full     = (level == LVL_FULL);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_ready;
  assign push     = (state_reg == CAPTURE) && (w_en != 2'b00);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign accept   = push && (!full || pop);
  assign eop_rise = eop & ~eop_q;
  assign eop_hit  = (state_reg == CAPTURE) && eop_rise && (eop_cnt == EOP_LAST);
  assign rd_data  = mem[rd_ptr_reg];

  always_comb begin
    level_next = level;
    if (accept && !pop)
      level_next = level + LVL_ONE;
    else if (!accept && pop)
      level_next = level - LVL_ONE;
  end

  // Storage is not reset: contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr_reg] <= {w_en, aD_rf, wD_rf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
      eop_cnt    <= 8'd0;
      signature  <= 16'd0;
      eop_q      <= 1'b0;
    end else begin
      eop_q <= eop;
      level <= level_next;
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        signature  <= signature ^ wD_rf;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !accept) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
      if ((state_reg == CAPTURE) && eop_rise)
        eop_cnt <= eop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= CAPTURE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CAPTURE:  if (eop_hit) state_next = DRAIN;
      DRAIN:    if (level_next == '0) state_next = FINISHED;
      FINISHED: state_next = FINISHED;
      default:  state_next = CAPTURE;
    endcase
  end

  always_comb begin
    done = (state_reg == FINISHED);
  end

endmodule

// File: tb/tb_wb_trace_capture.sv
// Bench for wb_trace_capture: directed scenarios plus randomized episodes, all
// checked every cycle against a queue-based model of the trace recorder.
module tb_wb_trace_capture;

  localparam int DEPTH     = 16;
  localparam int EOP_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  w_en = 2'b00;
  logic [2:0]  aD_rf = 3'd0;
  logic [15:0] wD_rf = 16'd0;
  logic        eop = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [20:0] rd_data;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [7:0]  eop_cnt;
  logic [15:0] signature;
  logic        done;

  wb_trace_capture #(.DEPTH(DEPTH), .EOP_LIMIT(EOP_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .aD_rf(aD_rf), .wD_rf(wD_rf),
    .eop(eop), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .eop_cnt(eop_cnt),
    .signature(signature), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  // Model: phase 0 = capturing, 1 = draining, 2 = finished.
  logic [20:0] mq[$];
  int          m_phase;
  int          m_drop;
  int          m_eops;
  bit          m_over;
  bit          m_eop_prev;
  logic [15:0] m_sig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_drop = 0; m_eops = 0; m_over = 1'b0; m_eop_prev = 1'b0; m_sig = 16'd0;
  endtask

  task automatic model_step(input logic [1:0] we, input logic [2:0] ad,
                            input logic [15:0] wd, input logic e, input logic rr);
    bit popped, rise;
    popped = (mq.size() != 0) && rr;
    rise   = e && !m_eop_prev;
    if (popped) void'(mq.pop_front());
    if (m_phase == 0 && we != 2'b00) begin
      if (mq.size() < DEPTH) begin
        mq.push_back({we, ad, wd});
        m_sig = m_sig ^ wd;
      end else begin
        m_over = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_eop_prev = e;
    if (m_phase == 0 && rise) begin
      m_eops++;
      if (m_eops == EOP_LIMIT) m_phase = 1;
    end else if (m_phase == 1 && mq.size() == 0) begin
      m_phase = 2;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
      check("level", 32'(level), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_over));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("eop_cnt", 32'(eop_cnt), 32'(m_eops));
      check("signature", 32'(signature), 32'(m_sig));
      check("done", 32'(done), 32'(m_phase == 2));
    end
  end

  task automatic cyc(input logic [1:0] we, input logic [2:0] ad, input logic [15:0] wd,
                     input logic e, input logic rr);
    w_en = we; aD_rf = ad; wD_rf = wd; eop = e; rd_ready = rr;
    @(posedge clk);
    model_step(we, ad, wd, e, rr);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_eop_cnt", 32'(eop_cnt), 32'd0);
    check("rst_signature", 32'(signature), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    w_en = 2'b00; eop = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] d [18];
    logic [15:0] exp_sig;
    logic [15:0] x;
    logic [1:0]  we;
    logic        e;
    logic        rr;
    int          rd_prob;

    do_reset();
    cmp_en = 1'b1;

    // Single write
    cyc(2'b11, 3'd3, 16'hBEEF, 1'b0, 1'b0);
    check("single_data", 32'(rd_data), 32'h1BBEEF);
    check("single_level", 32'(level), 32'd1);
    check("single_sig", 32'(signature), 32'hBEEF);
    $display("scenario single write: level=%0d data=%h", level, rd_data);

    // Fill and overflow
    do_reset();
    exp_sig = 16'd0;
    for (int i = 0; i < 18; i++) begin
      d[i] = 16'($urandom);
      if (i < 16) exp_sig = exp_sig ^ d[i];
      cyc(2'b01, 3'(i), d[i], 1'b0, 1'b0);
    end
    check("fill_level", 32'(level), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_drop", 32'(drop_cnt), 32'd2);
    check("fill_sig", 32'(signature), 32'(exp_sig));
    $display("scenario fill: level=%0d drops=%0d sig=%h", level, drop_cnt, signature);

    // Full with simultaneous pop: new entry accepted and ends up last
    x = 16'h1234;
    cyc(2'b10, 3'd7, x, 1'b0, 1'b1);
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 15; i++) cyc(2'b00, 3'd0, 16'd0, 1'b0, 1'b1);
    check("fullpop_order", 32'(rd_data[15:0]), 32'(x));
    check("fullpop_last_level", 32'(level), 32'd1);
    $display("scenario full+pop: tail entry %h", rd_data);

    // eop counting with pulse widths 1, 4, 2
    do_reset();
    for (int i = 0; i < 4; i++) cyc(2'b10, 3'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
    cyc(2'b00, 3'd0, 16'd0, 1'b1, 1'b0);
    check("eop_first", 32'(eop_cnt), 32'd1);
    cyc(2'b00, 3'd0, 16'd0, 1'b0, 1'b0);
    cyc(2'b00, 3'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(2'b00, 3'd0, 16'd0, 1'b1, 1'b0);
    check("eop_held", 32'(eop_cnt), 32'd2);
    cyc(2'b00, 3'd0, 16'd0, 1'b0, 1'b0);
    cyc(2'b01, 3'd5, 16'hC0DE, 1'b1, 1'b0);
    check("eop_third", 32'(eop_cnt), 32'd3);
    check("eop_write_kept", 32'(level), 32'd5);
    cyc(2'b01, 3'd6, 16'hDEAD, 1'b1, 1'b0);
    check("eop_write_ignored", 32'(level), 32'd5);
    $display("scenario eop: eop_cnt=%0d level=%0d", eop_cnt, level);

    // Drain to done
    check("drain_head", 32'(rd_data), 32'h10A000);
    for (int i = 0; i < 4; i++) cyc(2'b11, 3'd1, 16'hFFFF, 1'b1, 1'b1);
    check("drain_last", 32'(rd_data), 32'h0DC0DE);
    check("drain_not_done", 32'(done), 32'd0);
    cyc(2'b00, 3'd0, 16'd0, 1'b0, 1'b1);
    check("drain_done", 32'(done), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    cyc(2'b11, 3'd2, 16'h0F0F, 1'b1, 1'b1);
    check("done_sticky", 32'(done), 32'd1);
    $display("scenario drain: done=%0d level=%0d", done, level);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 3; i++) cyc(2'b01, 3'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(2'b00, 3'd0, 16'd0, 1'(i % 2 == 0), 1'b0);
    check("middrain_level", 32'(level), 32'd3);
    check("middrain_eop", 32'(eop_cnt), 32'd3);
    do_reset();
    cyc(2'b11, 3'd1, 16'h5555, 1'b1, 1'b0);
    check("after_rst_eop", 32'(eop_cnt), 32'd1);
    check("after_rst_level", 32'(level), 32'd1);
    $display("scenario reset mid-drain: eop_cnt=%0d level=%0d", eop_cnt, level);

    // Randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      rd_prob = int'($urandom_range(0, 4));
      e = 1'b0;
      for (int c = 0; c < 300; c++) begin
        we = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        if ($urandom_range(0, 24) == 0) e = ~e;
        rr = 1'(int'($urandom_range(0, 3)) < rd_prob);
        cyc(we, 3'($urandom), 16'($urandom), e, rr);
        if (c == 150 && ep % 4 == 1) do_reset();
      end
      $display("episode %0d: level=%0d drops=%0d eop_cnt=%0d done=%0d",
               ep, level, drop_cnt, eop_cnt, done);
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_trace_capture.md
# wb_trace_capture

Writeback trace recorder attached to the register-file write port of the pipelined processor. Every cycle with a non-zero write enable is captured as one trace entry (enable, destination register, data) into an internal FIFO. A consumer drains the FIFO through a valid/ready read port. The block counts end-of-program pulses and stops capturing after a programmable number of them, then reports completion.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..256
- EOP_LIMIT, 11: eop rising edges that end capture; 1..255
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- w_en  in  2  register-file write enable from writeback; 00 = no write
- aD_rf  in  3  register-file destination address
- wD_rf  in  16  register-file write data
- eop  in  1  end-of-program level from processor
- rd_valid  out  1  FIFO head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_data  out  21  head entry {w_en[1:0], aD_rf[2:0], wD_rf[15:0]}
- level  out  log2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: at least one entry dropped
- drop_cnt  out  8  dropped entries, saturating at 255
- eop_cnt  out  8  eop rising edges seen, saturating at EOP_LIMIT
- signature  out  16  running XOR of wD_rf over all accepted entries
- done  out  1  capture ended and FIFO empty

## Operation
- State machine: CAPTURE (after reset) -> DRAIN -> DONE.
- CAPTURE: push when w_en != 00. If FIFO full and no pop this cycle, drop the entry: overflow=1, drop_cnt++ (saturating), signature unchanged. Accepted entries XOR wD_rf into signature.
- eop edge detect: eop_q registers eop; a rise is eop & ~eop_q. Each rise in CAPTURE increments eop_cnt. When eop_cnt becomes EOP_LIMIT, move to DRAIN.
- DRAIN: ignore w_en and eop. Pops continue. Move to DONE on the edge where level becomes 0. If level is already 0 on entry, move to DONE the following edge.
- DONE: done=1. Ignore all inputs except rd_ready, which has no effect because the FIFO is empty. Only reset leaves DONE.
- Read port: show-ahead FIFO. rd_data is the head entry whenever rd_valid=1. A pop happens when rd_valid & rd_ready. rd_data is don't-care while rd_valid=0.
- Push and pop in the same cycle:
  - FIFO full: both happen, level unchanged, no drop.
  - FIFO empty: only the push happens. No write-through bypass.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full means level==DEPTH.

## Timing
- Reset values: rd_valid=0, level=0, overflow=0, drop_cnt=0, eop_cnt=0, signature=0, done=0, eop_q=0, state=CAPTURE, pointers=0. rd_data is don't-care.
- Capture latency is 1 cycle: a write sampled at edge N gives rd_valid=1 and updates level and signature after edge N.
- Pop takes effect at the edge where valid&ready; the next entry is presented after that edge.
- A write in the same cycle as the limit-reaching eop rise is still captured. Writes from the next cycle on are ignored.
- An eop held high counts once. It counts again only after going low for ≥1 cycle.
- An eop already high at reset release counts on the first edge, because eop_q=0.
- done rises 1 cycle after the pop that empties the FIFO in DRAIN.
- rst_n low at any time, including mid-drain, immediately forces all reset values. Contents are discarded.

## Test plan
- Single write: w_en=11, aD_rf=3, wD_rf=16'hBEEF for 1 cycle, rd_ready=0 -> next cycle rd_valid=1, rd_data=21'h1BBEEF ({11,011,BEEF}), level=1, signature=16'hBEEF.
- Fill and overflow (DEPTH=16, rd_ready=0): 18 consecutive writes -> level=16, overflow=1, drop_cnt=2, signature = XOR of the first 16 data words only.
- Full plus simultaneous pop: with FIFO full, write and rd_ready=1 in the same cycle -> level stays 16, no drop, new entry later appears last in order.
- eop counting (EOP_LIMIT=3): eop pulses of width 1, 4, and 2 cycles, separated by low gaps -> eop_cnt=1,2,3, state DRAIN after the third rise. A write on the third-rise cycle is captured; a write one cycle later is not.
- Drain to done: from DRAIN with level=5, hold rd_ready=1 -> 5 entries pop in FIFO order, done=1 one cycle after the last pop, level=0.
- Reset mid-drain: drop rst_n while level=3 in DRAIN -> all outputs at reset values immediately. After release, capture resumes and eop_cnt counts from 0.
